// File: rtl/md_unit_ctrl_pkg.sv
// Shared definitions for the multiply/divide sequencer: op encoding, default latencies, start predicate.
// Optional accumulate ops (MADD/MADDU/MSUB/MSUBU) exist only when MD_MADD_EN is defined.
package md_pkg;

   localparam int MD_OP_W            = 4;
   localparam int MD_CNT_W           = 4;
   localparam int MD_MULT_CYCLES_DEF = 5;
   localparam int MD_DIV_CYCLES_DEF  = 10;

   typedef enum logic [MD_OP_W-1:0] {
      MD_NONE  = 4'd0,
      MD_MULT  = 4'd1,
      MD_MULTU = 4'd2,
      MD_DIV   = 4'd3,
      MD_DIVU  = 4'd4,
      MD_MTHI  = 4'd5,
      MD_MTLO  = 4'd6,
      MD_MFHI  = 4'd7,
`ifdef MD_MADD_EN
      MD_MFLO  = 4'd8,
      MD_MADD  = 4'd9,
      MD_MADDU = 4'd10,
      MD_MSUB  = 4'd11,
      MD_MSUBU = 4'd12
`else
      MD_MFLO  = 4'd8
`endif
   } md_op_e;

   // True for every op that occupies the unit for multiple cycles.
   function automatic logic is_md_start(input logic [MD_OP_W-1:0] op);
      case (op)
         MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: is_md_start = 1'b1;
`ifdef MD_MADD_EN
         MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU: is_md_start = 1'b1;
`endif
         default: is_md_start = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/md_unit_ctrl_if.sv
// Stage-E issue / stage-D use signals and HI/LO results of the multiply/divide unit.
interface md_unit_ctrl_if;
   import md_pkg::*;

   logic                 e_md_valid;
   logic [MD_OP_W-1:0]   e_md_op;
   logic [31:0]          e_rs;
   logic [31:0]          e_rt;
   logic                 d_md_use;
   logic [31:0]          hi;
   logic [31:0]          lo;
   logic                 busy;
   logic                 md_stall;

   modport master (
      output e_md_valid, e_md_op, e_rs, e_rt, d_md_use,
      input  hi, lo, busy, md_stall
   );

   modport slave (
      input  e_md_valid, e_md_op, e_rs, e_rt, d_md_use,
      output hi, lo, busy, md_stall
   );
endinterface

// File: rtl/md_unit_ctrl_cycle_counter.sv
// Load/decrement latency counter; done marks the final busy cycle (count==1).
module md_cycle_counter #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   output logic         done_o,
   output logic         active_o
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign done_o   = (cnt_q == W'(1));
   assign active_o = (cnt_q != '0);

endmodule

// File: rtl/md_unit_ctrl.sv
// Multiply/divide sequencer: holds HI/LO, models busy latency, raises the D-stage stall.
// Build option: MD_MADD_EN adds the MADD/MADDU/MSUB/MSUBU accumulate ops.
module md_unit_ctrl
   import md_pkg::*;
#(
   parameter int MULT_CYCLES = MD_MULT_CYCLES_DEF,
   parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   md_unit_ctrl_if.slave     bus
);

   typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_e;

   state_e               state_q, state_d;
   logic [31:0]          hi_q, hi_d, lo_q, lo_d;
   logic [31:0]          pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
   logic                 pend_skip_q, pend_skip_d;
   logic                 cnt_load;
   logic [MD_CNT_W-1:0]  cnt_load_val;
   logic                 cnt_done, cnt_active;

   logic [31:0] rs, rt;
   assign rs = bus.e_rs;
   assign rt = bus.e_rt;

   // Operands are widened before multiplying so the low 64 bits are the exact product.
   logic [63:0] prod_s, prod_u;
   assign prod_s = {{32{rs[31]}}, rs} * {{32{rt[31]}}, rt};
   assign prod_u = {32'd0, rs} * {32'd0, rt};

   // Shared magnitude divider; signs are reapplied afterwards (truncate toward zero).
   logic        div_signed, rs_neg, rt_neg;
   logic [31:0] rs_mag, rt_mag, rt_safe, q_mag, r_mag, quot, rem;
   assign div_signed = (bus.e_md_op == MD_DIV);
   assign rs_neg     = div_signed & rs[31];
   assign rt_neg     = div_signed & rt[31];
   assign rs_mag     = rs_neg ? (32'd0 - rs) : rs;
   assign rt_mag     = rt_neg ? (32'd0 - rt) : rt;
   assign rt_safe    = (rt_mag == 32'd0) ? 32'd1 : rt_mag;
   assign q_mag      = rs_mag / rt_safe;
   assign r_mag      = rs_mag % rt_safe;
   assign quot       = (rs_neg ^ rt_neg) ? (32'd0 - q_mag) : q_mag;
   assign rem        = rs_neg ? (32'd0 - r_mag) : r_mag;

   md_cycle_counter #(.W(MD_CNT_W)) u_cnt (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_i     (cnt_load),
      .load_val_i (cnt_load_val),
      .done_o     (cnt_done),
      .active_o   (cnt_active)
   );

   always_comb begin
      state_d      = state_q;
      hi_d         = hi_q;
      lo_d         = lo_q;
      pend_hi_d    = pend_hi_q;
      pend_lo_d    = pend_lo_q;
      pend_skip_d  = pend_skip_q;
      cnt_load     = 1'b0;
      cnt_load_val = '0;

      case (state_q)
         ST_IDLE: begin
            if (bus.e_md_valid) begin
               if (is_md_start(bus.e_md_op)) begin
                  state_d      = ST_RUN;
                  cnt_load     = 1'b1;
                  cnt_load_val = MD_CNT_W'(MULT_CYCLES);
                  pend_skip_d  = 1'b0;
               end
               case (bus.e_md_op)
                  MD_MULT:  {pend_hi_d, pend_lo_d} = prod_s;
                  MD_MULTU: {pend_hi_d, pend_lo_d} = prod_u;
                  MD_DIV, MD_DIVU: begin
                     cnt_load_val = MD_CNT_W'(DIV_CYCLES);
                     pend_hi_d    = rem;
                     pend_lo_d    = quot;
                     pend_skip_d  = (rt == 32'd0);
                  end
`ifdef MD_MADD_EN
                  MD_MADD:  {pend_hi_d, pend_lo_d} = {hi_q, lo_q} + prod_s;
                  MD_MADDU: {pend_hi_d, pend_lo_d} = {hi_q, lo_q} + prod_u;
                  MD_MSUB:  {pend_hi_d, pend_lo_d} = {hi_q, lo_q} - prod_s;
                  MD_MSUBU: {pend_hi_d, pend_lo_d} = {hi_q, lo_q} - prod_u;
`endif
                  MD_MTHI:  hi_d = rs;
                  MD_MTLO:  lo_d = rs;
                  default: ;
               endcase
            end
         end
         ST_RUN: begin
            // Any op issued while running is ignored; only completion matters here.
            if (cnt_done) begin
               state_d = ST_IDLE;
               if (!pend_skip_q) begin
                  hi_d = pend_hi_q;
                  lo_d = pend_lo_q;
               end
            end else if (!cnt_active) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         hi_q        <= '0;
         lo_q        <= '0;
         pend_hi_q   <= '0;
         pend_lo_q   <= '0;
         pend_skip_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         hi_q        <= hi_d;
         lo_q        <= lo_d;
         pend_hi_q   <= pend_hi_d;
         pend_lo_q   <= pend_lo_d;
         pend_skip_q <= pend_skip_d;
      end
   end

   assign bus.hi       = hi_q;
   assign bus.lo       = lo_q;
   assign bus.busy     = (state_q == ST_RUN);
   assign bus.md_stall = bus.d_md_use &
                         (bus.busy | (bus.e_md_valid & is_md_start(bus.e_md_op)));

endmodule

// File: doc/md_unit_ctrl.md
Name: md_unit_ctrl

Overview:
- Sequencer for the shared multiply/divide resource in the 5-stage MIPS pipeline.
- Accepts one MD operation per issue from stage E and holds the HI/LO architectural registers.
- Models multi-cycle busy latency and generates the MD stall term that the hazard unit ORs into the D-stage stall.
- mfhi/mflo read `hi` and `lo` combinationally. The hazard unit forwards nothing for HI/LO, because md_stall already serialises all accesses.

Parameters:
MULT_CYCLES, 5, busy cycles for mult/multu (legal range 1..15)
DIV_CYCLES, 10, busy cycles for div/divu (legal range 1..15)

Ports:
clk  in  1  pipeline clock
rst_n  in  1  asynchronous active-low reset
e_md_valid  in  1  stage-E instruction is an MD op and is not bubbled
e_md_op  in  4  op code from md_pkg: NONE, MULT, MULTU, DIV, DIVU, MTHI, MTLO, MFHI, MFLO (plus MADD group when enabled)
e_rs  in  32  forwarded rs value in stage E
e_rt  in  32  forwarded rt value in stage E
d_md_use  in  1  stage-D instruction is any MD op (including mfhi/mflo/mthi/mtlo)
hi  out  32  HI register
lo  out  32  LO register
busy  out  1  an operation is in progress
md_stall  out  1  D-stage stall request

Behaviour:
- Reset (asynchronous, rst_n=0):
  - hi=0, lo=0, busy=0, internal counter=0.
  - Pending result is discarded.
  - This includes a reset asserted mid-operation: no partial commit occurs.
- FSM has two states:
  - IDLE: busy=0.
  - RUN: busy=1.
- IDLE to RUN, on an edge with e_md_valid=1 and op in {MULT, MULTU, DIV, DIVU}:
  - Compute the result into pending_hi/pending_lo.
  - Load counter with MULT_CYCLES or DIV_CYCLES.
- In RUN, the counter decrements every edge.
  - On the edge where counter==1: hi/lo <= pending, counter -> 0, busy -> 0, state returns to IDLE.
  - busy is therefore high for exactly N cycles after the start edge.
  - The new hi/lo are visible in the same cycle busy falls.
- MTHI/MTLO in IDLE: hi<=e_rs or lo<=e_rs at that edge. Zero latency, no RUN.
- MFHI/MFLO: no state change.
- NONE, or e_md_valid=0: no state change.
- Any e_md_valid op arriving while busy=1 is a protocol violation (md_stall prevents it).
  - Required response: the op is ignored and the in-progress op completes unchanged.
- md_stall = d_md_use & (busy | (e_md_valid & e_md_op in {MULT, MULTU, DIV, DIVU})).
  - This is purely combinational, with no registered delay.
- Arithmetic:
  - MULT/MULTU: {hi,lo} = 64-bit signed/unsigned product.
  - DIV/DIVU: lo = quotient truncated toward zero, hi = remainder carrying the dividend's sign.
  - Signed 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
  - Divisor 0: the op still runs DIV_CYCLES, but hi/lo stay unchanged at completion.
- Back-to-back: a new start is accepted in the cycle after busy falls, never in the same cycle.

Optional Feature:
- MD_MADD_EN defined:
  - Adds op codes MADD, MADDU, MSUB, MSUBU.
  - At completion, {hi,lo} <= {hi,lo} ± product (signed/unsigned as named), with latency MULT_CYCLES.
  - The accumulate base is sampled from hi/lo at the start edge.
  - These ops are included in the md_stall start term.
- MD_MADD_EN undefined:
  - Those codes do not exist in md_pkg.
  - Any unlisted op code is treated as NONE.

Decomposition:
- md_pkg holds:
  - The 4-bit md_op enumeration and its width constant.
  - Default cycle constants.
  - The predicate function is_md_start(op).
- The hazard unit imports md_pkg for d_md_use decode.
- One sub-module, md_cycle_counter, holds the load/decrement counter.
  - It outputs done (counter==1) and active.
  - md_unit_ctrl instantiates it once.

Test Plan:
1. Reset, then MULT rs=0xFFFFFFFD (-3), rt=5 → busy high 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFF1; busy=0.
2. MULTU rs=0xFFFFFFFF, rt=2 → after 5 cycles hi=1, lo=0xFFFFFFFE. Hold d_md_use=1 throughout → md_stall high in start cycle plus 5 busy cycles, low after.
3. DIV rs=7, rt=0xFFFFFFFE (-2) → after 10 cycles lo=0xFFFFFFFD, hi=1. DIVU with rt=0, starting from hi=0x11, lo=0x22 → busy 10 cycles, hi/lo unchanged.
4. MTHI rs=0xDEADBEEF → hi=0xDEADBEEF at the next edge, busy never rises. Then MFLO → no state change.
5. Start DIV, assert rst_n=0 at cycle 4 → hi=lo=0 and busy=0 immediately (asynchronous). After release, no commit occurs.
6. With MD_MADD_EN: hi=0, lo=0xFFFFFFFF; MADDU 1×1 → after 5 cycles hi=1, lo=0.
